// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: the queued IF/ID entry, the ack FSM states and
// the instruction-extraction helper used at capture time.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misaligned;
  } if_id_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } ack_state_t;

  // pc[2] picks which half of the 64-bit cache word holds the instruction
  function automatic if_id_entry_t extract_entry(input logic [XLEN-1:0] word,
                                                 input logic [XLEN-1:0] pc);
    if_id_entry_t e;
    e.instr      = pc[2] ? word[63:32] : word[31:0];
    e.pc         = pc;
    e.misaligned = |pc[1:0];
    return e;
  endfunction

endpackage

// File: rtl/if_id_fifo.sv
// Generic DEPTH-entry synchronous FIFO of IF/ID entries with clear.
// clear wins over push/pop; a full FIFO accepts a push when it pops the same cycle.
module if_id_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  if_id_entry_t             wdata,
  output if_id_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  if_id_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage; zeroed on reset so the decoder-facing data reads 0 out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID buffer: captures one entry per fetcher_done assertion, acks the fetcher
// with a one-cycle pulse, and queues entries for the decoder. Flush empties the
// queue but still acks a pending fetch so the fetcher is released.
module if_id_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64   // must match fetch_pkg::XLEN (entry layout)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetcher_done,
  input  logic [XLEN-1:0]        fetch_word,
  input  logic [XLEN-1:0]        fetch_pc,
  input  logic                   flush,
  output logic                   if_id_pipeline_valid,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_instr,
  output logic [XLEN-1:0]        id_pc,
  output logic                   id_misaligned,
  output logic [$clog2(DEPTH):0] fifo_count
);

  ack_state_t   state, state_nxt;
  logic         done_seen;
  logic         pop, cap, push, full, empty;
  if_id_entry_t wentry, head;

  assign pop    = id_valid && id_ready;
  // during flush nothing is written, so room is not needed to ack
  assign cap    = fetcher_done && !done_seen && (flush || !full || pop);
  assign push   = cap && !flush;
  assign wentry = extract_entry(fetch_word, fetch_pc);

  if_id_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata (wentry),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign id_valid      = !empty;
  assign id_instr      = head.instr;
  assign id_pc         = head.pc;
  assign id_misaligned = head.misaligned;

  assign if_id_pipeline_valid = (state == ACK);

  // ack state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ack lasts exactly one cycle after each capture
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done_seen edge-qualifies fetcher_done: one assertion yields one capture
  always_ff @(posedge clk) begin
    if (reset)             done_seen <= 1'b0;
    else if (!fetcher_done) done_seen <= 1'b0;
    else if (cap)          done_seen <= 1'b1;
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios then random traffic,
// all checked every cycle against a queue-based reference model.
module tb_if_id_buffer;

  localparam int DEPTH = 2;
  localparam int XLEN  = 64;

  logic            clk = 1'b0;
  logic            reset, fetcher_done, flush, id_ready;
  logic [XLEN-1:0] fetch_word, fetch_pc;
  logic            if_id_pipeline_valid, id_valid, id_misaligned;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [$clog2(DEPTH):0] fifo_count;

  if_id_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk                  (clk),
    .reset                (reset),
    .fetcher_done         (fetcher_done),
    .fetch_word           (fetch_word),
    .fetch_pc             (fetch_pc),
    .flush                (flush),
    .if_id_pipeline_valid (if_id_pipeline_valid),
    .id_valid             (id_valid),
    .id_ready             (id_ready),
    .id_instr             (id_instr),
    .id_pc                (id_pc),
    .id_misaligned        (id_misaligned),
    .fifo_count           (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            mis;
  } ent_t;

  ent_t q[$];
  bit   m_ack, m_seen;
  int   ncmp = 0, nerr = 0, nack = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge worth of the buffer's rules.
  task automatic model_edge(input bit rst, input bit fd, input logic [63:0] w,
                            input logic [63:0] pc, input bit fl, input bit rdy);
    bit   pop, cap;
    ent_t e;
    if (rst) begin
      q.delete(); m_ack = 0; m_seen = 0;
      return;
    end
    pop = (q.size() != 0) && rdy;
    cap = fd && !m_seen && (fl || q.size() < DEPTH || pop);
    m_ack = cap;
    e.instr = ((pc >> 2) % 2 == 1) ? 32'(w >> 32) : 32'(w % (64'd1 << 32));
    e.pc    = pc;
    e.mis   = (pc % 4) != 0;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (cap) q.push_back(e);
    end
    m_seen = fd ? (m_seen || cap) : 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ack"},   64'(if_id_pipeline_valid), 64'(m_ack));
    chk({tag, ".valid"}, 64'(id_valid),             64'(q.size() != 0));
    chk({tag, ".count"}, 64'(fifo_count),           64'(q.size()));
    if (q.size() != 0) begin
      chk({tag, ".instr"}, 64'(id_instr),      64'(q[0].instr));
      chk({tag, ".pc"},    id_pc,              q[0].pc);
      chk({tag, ".mis"},   64'(id_misaligned), 64'(q[0].mis));
    end
    if (if_id_pipeline_valid) nack++;
  endtask

  task automatic step(input string tag, input bit rst, input bit fd,
                      input logic [63:0] w, input logic [63:0] pc,
                      input bit fl, input bit rdy);
    reset = rst; fetcher_done = fd; fetch_word = w; fetch_pc = pc;
    flush = fl; id_ready = rdy;
    model_edge(rst, fd, w, pc, fl, rdy);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  localparam logic [63:0] W = 64'hAAAA_BBBB_1111_2222;

  initial begin
    reset = 1; fetcher_done = 0; flush = 0; id_ready = 0;
    fetch_word = '0; fetch_pc = '0;

    // reset state
    step("rst", 1, 0, 0, 0, 0, 0);
    chk("rst.instr0", 64'(id_instr), 64'd0);
    chk("rst.pc0",    id_pc,         64'd0);
    chk("rst.mis0",   64'(id_misaligned), 64'd0);

    // basic capture, lower half
    step("cap0", 0, 1, W, 64'h1000, 0, 0);
    chk("cap0.instr", 64'(id_instr), 64'h1111_2222);
    step("cap0b", 0, 0, 0, 0, 0, 1);
    // upper half, then misaligned
    step("up", 0, 1, W, 64'h1004, 0, 0);
    chk("up.instr", 64'(id_instr), 64'hAAAA_BBBB);
    step("upb", 0, 0, 0, 0, 0, 1);
    step("mis", 0, 1, W, 64'h1006, 0, 0);
    chk("mis.flag", 64'(id_misaligned), 64'd1);
    step("misb", 0, 0, 0, 0, 0, 1);

    // level-held fetcher_done: one entry, one ack
    nack = 0;
    for (int i = 0; i < 4; i++) step("hold", 0, 1, W, 64'h2000, 0, 0);
    step("hold_end", 0, 0, 0, 0, 0, 0);
    chk("hold.acks",  64'(nack), 64'd1);
    chk("hold.count", 64'(fifo_count), 64'd1);
    step("drain", 0, 0, 0, 0, 0, 1);

    // backpressure: fill, stall third fetch, then pop+capture same cycle
    step("bp1", 0, 1, W, 64'h3000, 0, 0);
    step("bp1e", 0, 0, 0, 0, 0, 0);
    step("bp2", 0, 1, W, 64'h3008, 0, 0);
    step("bp2e", 0, 0, 0, 0, 0, 0);
    nack = 0;
    for (int i = 0; i < 3; i++) step("bp3stall", 0, 1, W, 64'h3010, 0, 0);
    chk("bp3.noack", 64'(nack), 64'd0);
    step("bp3pop", 0, 1, W, 64'h3010, 0, 1);
    chk("bp3.ack",   64'(if_id_pipeline_valid), 64'd1);
    chk("bp3.count", 64'(fifo_count), 64'd2);
    chk("bp3.head",  id_pc, 64'h3008);
    step("bp3e", 0, 0, 0, 0, 0, 0);

    // flush with full FIFO and a new fetch: acked, not written
    step("flush", 0, 1, W, 64'h4000, 1, 0);
    chk("flush.count", 64'(fifo_count), 64'd0);
    chk("flush.ack",   64'(if_id_pipeline_valid), 64'd1);
    step("flushe", 0, 0, 0, 0, 0, 0);

    // reset during ACK drops the pulse
    step("rack0", 0, 1, W, 64'h5000, 0, 0);
    step("rack1", 1, 1, W, 64'h5000, 0, 0);
    chk("rack.ack", 64'(if_id_pipeline_valid), 64'd0);
    step("rack2", 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [63:0] w, pc;
      w  = {$urandom, $urandom};
      pc = {32'h0, $urandom};
      step("rnd", ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), w, pc,
           ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
